rx_bit_timer: RTL

//  Bit-period timer for the UART receiver; consumes enable_timer from the receiver control FSM.

---
 rtl/rx_bit_timer_pkg.sv | 15 +
 rtl/rx_bit_timer_if.sv | 26 ++
 rtl/rx_bit_timer_flex_counter.sv | 32 +++
 rtl/rx_bit_timer.sv | 82 ++++++++
 4 files changed

// File: rtl/rx_bit_timer_pkg.sv
// Shared UART receiver definitions: timer FSM encoding and default frame geometry
// used by the control FSM, the bit timer and the shift register.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  localparam int DEF_CLKS_PER_BIT = 10;
  localparam int DEF_SAMPLE_PT    = 9;
  localparam int DEF_DATA_BITS    = 8;

endpackage

// File: rtl/rx_bit_timer_if.sv
// Control-FSM <-> bit-timer link. Master is the control FSM, slave is the timer.
// enable_timer is a level request, not a handshake: high runs one frame, low aborts/re-arms.
interface rx_bit_timer_if
  import uart_rx_pkg::*;
#(
  parameter int BW = 4
) ();

  logic          enable_timer;
  logic          shift_strobe;
  logic          packet_done;
  logic [BW-1:0] bit_idx;
  logic          busy;
  timer_state_t  state_dbg;

  modport master (
    output enable_timer,
    input  shift_strobe, packet_done, bit_idx, busy, state_dbg
  );

  modport slave (
    input  enable_timer,
    output shift_strobe, packet_done, bit_idx, busy, state_dbg
  );

endinterface

// File: rtl/rx_bit_timer_flex_counter.sv
// Generic up-counter with synchronous clear and wrap to zero after rollover_val.
// Clear has priority over count_enable.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out
);

  logic [NUM_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_out = count_q;

endmodule

// File: rtl/rx_bit_timer.sv
// UART receiver bit-period timer: one shift_strobe per bit period, DATA_BITS+1 strobes
// per frame (data plus stop bit), then a one-cycle packet_done back to the control FSM.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int SAMPLE_PT    = DEF_SAMPLE_PT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input logic          clk,
  input logic          n_rst,
  rx_bit_timer_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 2);

  timer_state_t  state_q, state_d;
  logic          packet_done_q, packet_done_d;
  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_idx;
  logic          enable;
  logic          shift_strobe;
  logic          last_strobe;

  assign enable = bus.enable_timer;

  // Strobe is decoded purely from registered count/state plus enable, so dropping
  // enable kills it in the same cycle.
  assign shift_strobe = enable && (state_q != DONE) && (clk_cnt == CW'(SAMPLE_PT));
  assign last_strobe  = shift_strobe && (bit_idx == BW'(DATA_BITS));

  flex_counter #(.NUM_BITS(CW)) u_cycle_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!enable || (state_q == DONE)),
    .count_enable (1'b1),
    .rollover_val (CW'(CLKS_PER_BIT - 1)),
    .count_out    (clk_cnt)
  );

  // Gating count_enable at DATA_BITS+1 makes the bit counter saturate instead of wrap.
  flex_counter #(.NUM_BITS(BW)) u_bit_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (!enable),
    .count_enable (shift_strobe && (bit_idx != BW'(DATA_BITS + 1))),
    .rollover_val (BW'(DATA_BITS + 1)),
    .count_out    (bit_idx)
  );

  always_comb begin
    state_d       = state_q;
    packet_done_d = last_strobe;
    unique case (state_q)
      IDLE: if (enable) state_d = last_strobe ? DONE : RUN;
      RUN: begin
        if (!enable)          state_d = IDLE;
        else if (last_strobe) state_d = DONE;
      end
      DONE: if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      packet_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      packet_done_q <= packet_done_d;
    end
  end

  assign bus.shift_strobe = shift_strobe;
  assign bus.packet_done  = packet_done_q;
  assign bus.bit_idx      = bit_idx;
  assign bus.busy         = (state_q == RUN);
  assign bus.state_dbg    = state_q;

endmodule
